// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the timing generator.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counter end points and sync windows (inclusive), all derived from the table above.
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_LIM = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_LIM = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // True when v lies in the inclusive window lo..hi.
  function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth shift register for sync signals; idles at 1 (inactive sync).
module sync_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Zero depth: straight wire; clock and reset are intentionally unused.
      logic unused_ok;
      assign unused_ok = clk ^ rst;
      assign q = d;
    end else begin : g_shift
      logic [DEPTH-1:0] sr;

      // Shift d in at the bottom; the oldest sample leaves at the top.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '1;
        else     sr <= DEPTH'({sr, d});
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster counter with registered, counter-aligned blank/sync/frame flags.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int PIPE_DELAY = 2,
  parameter int FRAME_W    = 16
) (
  input  logic               vga_clk,
  input  logic               reset,
  output logic [9:0]         DrawX,
  output logic [9:0]         DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               hs_d,
  output logic               vs_d,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       line_end;
  logic       frame_end;
  logic       running;

  // Next raster position; wraps are explicit compares, never counter overflow.
  always_comb begin
    line_end  = (DrawX == H_LAST);
    frame_end = line_end && (DrawY == V_LAST);
    x_nxt     = line_end ? 10'd0 : DrawX + 10'd1;
    y_nxt     = DrawY;
    if (line_end) y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
  end

  // Counters plus flags decoded from the next position so they line up with DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      running     <= 1'b0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank       <= (x_nxt < H_VIS_LIM) && (y_nxt < V_VIS_LIM);
      hs          <= ~in_window(x_nxt, HS_START, HS_END);
      vs          <= ~in_window(y_nxt, VS_START, VS_END);
      frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
      running     <= 1'b1;
      // The reset-state position also looks like a frame end; only count real frames.
      if (running && frame_end) frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  sync_delay #(.DEPTH(PIPE_DELAY)) u_hs_delay (
    .clk (vga_clk),
    .rst (reset),
    .d   (hs),
    .q   (hs_d)
  );

  sync_delay #(.DEPTH(PIPE_DELAY)) u_vs_delay (
    .clk (vga_clk),
    .rst (reset),
    .d   (vs),
    .q   (vs_d)
  );

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter PIPE_DELAY, default 2: cycles of delay on hs_d/vs_d so they match the sprite-mapper ROM+register latency.
REQ-002 Parameter FRAME_W, default 16: width of frame_cnt.
REQ-003 vga_clk  in  1  pixel clock (25 MHz); the block's only clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 DrawX  out  10  current horizontal pixel count, 0..799.
REQ-006 DrawY  out  10  current vertical line count, 0..524.
REQ-007 blank  out  1  1 = visible pixel (DrawX<640 and DrawY<480); 0 = blanking; aligned with DrawX/DrawY.
REQ-008 hs  out  1  horizontal sync, active low, aligned with DrawX/DrawY.
REQ-009 vs  out  1  vertical sync, active low, aligned with DrawX/DrawY.
REQ-010 hs_d, vs_d  out  1 each  hs/vs delayed by PIPE_DELAY cycles, for the VGA connector.
REQ-011 frame_start  out  1  one-cycle pulse while DrawX=0 and DrawY=0.
REQ-012 frame_cnt  out  FRAME_W  count of completed frames.

Function
REQ-013 Timing: horizontal 640 visible, 16 front porch, 96 sync, 48 back porch, 800 total; vertical 480, 10, 2, 33, 525 total.
REQ-014 DrawX increments by 1 each cycle; at 799 it wraps to 0.
REQ-015 DrawY increments by 1 only on the DrawX 799->0 wrap; at 524 it wraps to 0 on that same edge.
REQ-016 hs = 0 exactly for DrawX in 656..751; otherwise 1.
REQ-017 vs = 0 exactly for DrawY in 490..491, for all 800 pixels of those lines; otherwise 1.
REQ-018 blank, hs, vs and frame_start are registered and decoded from the counter's next value, so each is valid in the same cycle as the DrawX/DrawY it describes; zero combinational delay relative to the counters.
REQ-019 frame_cnt increments by 1 on the edge where (DrawX,DrawY) goes (799,524)->(0,0); it wraps modulo 2^FRAME_W.
REQ-020 hs_d/vs_d are a PIPE_DELAY-stage shift of hs/vs; PIPE_DELAY=0 makes them equal to hs/vs.
REQ-021 Counters use explicit wrap compares; no reliance on natural overflow of the 10-bit counters.

Reset
REQ-022 While reset=1: DrawX=799, DrawY=524, blank=0, hs=1, vs=1, hs_d=1, vs_d=1, frame_start=0, frame_cnt=0.
REQ-023 First rising edge after reset deasserts: DrawX=0, DrawY=0, blank=1, frame_start=1; frame_cnt stays 0 (no increment on that edge).
REQ-024 Reset asserted mid-frame forces REQ-022 values immediately, without waiting for a clock; delay stages clear to 1.

Structure
REQ-025 Package vga_timing_pkg holds H_VISIBLE, H_FP, H_SYNC, H_BP, H_TOTAL, V_VISIBLE, V_FP, V_SYNC, V_BP, V_TOTAL; derived sync start/end values come from these constants.
REQ-026 One sub-module, sync_delay: a parameterised-depth shift register with reset value 1, instantiated once per sync signal.

Verification
REQ-027 Release reset, run 800 cycles -> DrawX sequence 0..799, hs low for exactly 96 cycles starting at DrawX=656, blank high for exactly 640 cycles.
REQ-028 Run 2 full frames (840000 cycles) -> frame_start pulses at cycles 0 and 420000, frame_cnt=1 after the first wrap and 2 after the second, vs low for exactly 1600 cycles per frame starting at DrawY=490, DrawX=0.
REQ-029 At DrawX=799, DrawY=479, clock once -> DrawX=0, DrawY=480, blank=0 for the whole line.
REQ-030 Assert reset asynchronously at DrawX=300, DrawY=200 -> outputs take REQ-022 values before the next edge; after release, the REQ-023 sequence repeats.
REQ-031 PIPE_DELAY=2: hs_d falls exactly 2 cycles after hs falls and rises exactly 2 cycles after hs rises; PIPE_DELAY=0: hs_d equals hs every cycle.
REQ-032 Preload frame_cnt to 16'hFFFF, complete a frame -> frame_cnt=0.
